// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: opcodes, slice mux selects, sequencer states
// and the opcode-to-slice-control decode.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SLT  = 3'd3,
        OP_AND  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_OR   = 3'd7
    } alu_op_t;

    localparam logic [2:0] SEL_SUM  = 3'd0;
    localparam logic [2:0] SEL_XOR  = 3'd2;
    localparam logic [2:0] SEL_NOR  = 3'd4;
    localparam logic [2:0] SEL_NAND = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    typedef struct packed {
        logic [2:0] sel;
        logic       invta;
        logic       invtb;
        logic       cin0;
    } slice_ctrl_t;

    // AND/OR reuse the NOR/NAND gates through De Morgan with both inputs inverted.
    function automatic slice_ctrl_t decode_op(input alu_op_t op);
        slice_ctrl_t c;
        c = '{sel: SEL_SUM, invta: 1'b0, invtb: 1'b0, cin0: 1'b0};
        case (op)
            OP_ADD:  c = '{sel: SEL_SUM,  invta: 1'b0, invtb: 1'b0, cin0: 1'b0};
            OP_SUB,
            OP_SLT:  c = '{sel: SEL_SUM,  invta: 1'b0, invtb: 1'b1, cin0: 1'b1};
            OP_XOR:  c = '{sel: SEL_XOR,  invta: 1'b0, invtb: 1'b0, cin0: 1'b0};
            OP_NAND: c = '{sel: SEL_NAND, invta: 1'b0, invtb: 1'b0, cin0: 1'b0};
            OP_NOR:  c = '{sel: SEL_NOR,  invta: 1'b0, invtb: 1'b0, cin0: 1'b0};
            OP_AND:  c = '{sel: SEL_NOR,  invta: 1'b1, invtb: 1'b1, cin0: 1'b0};
            OP_OR:   c = '{sel: SEL_NAND, invta: 1'b1, invtb: 1'b1, cin0: 1'b0};
            default: c = '{sel: SEL_SUM,  invta: 1'b0, invtb: 1'b0, cin0: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: optional input inversion, full adder, xor/nand/nor
// and a select mux; overflow is this bit's carry-in XOR carry-out.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_cin,
    input  logic       i_invta,
    input  logic       i_invtb,
    input  logic [2:0] i_sel,
    output logic       o_result,
    output logic       o_cout,
    output logic       o_overflow
);

    logic w_a;
    logic w_b;
    logic w_sum;

    assign w_a        = i_a ^ i_invta;
    assign w_b        = i_b ^ i_invtb;
    assign w_sum      = w_a ^ w_b ^ i_cin;
    assign o_cout     = (w_a & w_b) | (i_cin & (w_a ^ w_b));
    assign o_overflow = i_cin ^ o_cout;

    always_comb begin
        o_result = 1'b0;
        case (i_sel)
            SEL_SUM:  o_result = w_sum;
            SEL_XOR:  o_result = w_a ^ w_b;
            SEL_NOR:  o_result = ~(w_a | w_b);
            SEL_NAND: o_result = ~(w_a & w_b);
            default:  o_result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_bitserial.sv
// Bit-serial ALU sequencer: accepts a request, walks one slice across the word LSB
// first with the carry fed back, then presents result and flags until consumed.
//
//   state | meaning
//   IDLE  | start_ready high, waiting for a request
//   RUN   | one operand bit per cycle through the slice
//   DONE  | done_valid high, outputs held until done_ready
module alu_bitserial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    serial_state_t    r_state;
    alu_op_t          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_nz;
    logic             r_done_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carryout;
    logic             r_overflow;
    logic             r_zero;

    slice_ctrl_t w_ctrl;
    logic        w_bit;
    logic        w_cout;
    logic        w_ovf;
    logic        w_arith;
    logic        w_slt;

    assign w_ctrl  = decode_op(r_op);
    assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
    assign w_slt   = w_bit ^ w_ovf;

    alu_bit_slice u_slice (
        .i_a        (r_a[0]),
        .i_b        (r_b[0]),
        .i_cin      (r_carry),
        .i_invta    (w_ctrl.invta),
        .i_invtb    (w_ctrl.invtb),
        .i_sel      (w_ctrl.sel),
        .o_result   (w_bit),
        .o_cout     (w_cout),
        .o_overflow (w_ovf)
    );

    // Result bits shift into the top of the A register as A drains out the bottom,
    // so after WIDTH cycles r_a holds the completed word without a separate shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_op         <= OP_ADD;
            r_a          <= '0;
            r_b          <= '0;
            r_cnt        <= '0;
            r_carry      <= 1'b0;
            r_nz         <= 1'b0;
            r_done_valid <= 1'b0;
            r_result     <= '0;
            r_carryout   <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_op    <= alu_op_t'(op);
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt   <= '0;
                        r_nz    <= 1'b0;
                        r_carry <= decode_op(alu_op_t'(op)).cin0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= {w_bit, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_nz    <= r_nz | w_bit;
                    if (r_cnt == LAST) begin
                        r_state      <= DONE;
                        r_done_valid <= 1'b1;
                        if (r_op == OP_SLT) begin
                            r_result   <= {{(WIDTH-1){1'b0}}, w_slt};
                            r_zero     <= ~w_slt;
                            r_carryout <= 1'b0;
                            r_overflow <= 1'b0;
                        end else begin
                            r_result   <= {w_bit, r_a[WIDTH-1:1]};
                            r_zero     <= ~(r_nz | w_bit);
                            r_carryout <= w_arith & w_cout;
                            r_overflow <= w_arith & w_ovf;
                        end
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        r_state      <= IDLE;
                        r_done_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start_ready = (r_state == IDLE);
    assign done_valid  = r_done_valid;
    assign result      = r_result;
    assign carryout    = r_carryout;
    assign overflow    = r_overflow;
    assign zero        = r_zero;

endmodule

// File: tb/tb_alu_bitserial.sv
// Randomized and directed bench for alu_bitserial against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_bitserial;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_valid;
    logic         start_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] prev_res;

    always #5 clk = ~clk;

    alu_bitserial #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .result      (result),
        .carryout    (carryout),
        .overflow    (overflow),
        .zero        (zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic c, output logic v, output logic z);
        logic [W:0] s;
        r = '0; c = 1'b0; v = 1'b0;
        case (o)
            3'd0: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[W-1:0]; c = s[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd1: begin
                s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                r = s[W-1:0]; c = s[W];
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd2: r = x ^ y;
            3'd3: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            3'd4: r = x & y;
            3'd5: r = ~(x & y);
            3'd6: r = ~(x | y);
            default: r = x | y;
        endcase
        z = (r == '0);
    endfunction

    // Issue one request, check latency, hold-off of partial results, final outputs,
    // back-pressure for 'hold' cycles, then release.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold);
        logic [W-1:0] er;
        logic         ec, ev, ez;
        int           cyc;
        logic         leak;
        model(o, x, y, er, ec, ev, ez);
        @(negedge clk);
        chk("ready_idle", start_ready, 1'b1);
        start_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start_valid = $urandom_range(0, 1);
        op = 3'($urandom); a = $urandom; b = $urandom;
        cyc = 0; leak = 1'b0;
        while (!done_valid && cyc < 100) begin
            if (result !== prev_res || start_ready !== 1'b0) leak = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(W));
        chk("run_hold", leak, 1'b0);
        chk("result", result, er);
        chk("flags", {carryout, overflow, zero}, {ec, ev, ez});
        for (int i = 0; i < hold; i++) begin
            done_ready = 1'b0;
            start_valid = 1'b1; a = $urandom; b = $urandom; op = 3'($urandom);
            @(posedge clk);
            #1;
            chk("bp_hold", {done_valid, start_ready, carryout, overflow, zero, result},
                {1'b1, 1'b0, ec, ev, ez, er});
        end
        start_valid = 1'b0;
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        chk("release", {done_valid, start_ready}, 2'b01);
        chk("out_keep", {carryout, overflow, zero, result}, {ec, ev, ez, er});
        prev_res = er;
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;
        reset = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
        op = '0; a = '0; b = '0; prev_res = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {start_ready, done_valid, carryout, overflow, zero, result},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        @(negedge clk);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(3'd1, 32'h8000_0000, 32'h0000_0001, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        run_op(3'd3, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        run_op(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        run_op(3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        run_op(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        run_op(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        run_op(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        run_op(3'd1, 32'h0000_0005, 32'h0000_0005, 5);

        // Reset in the middle of a run: nothing partial may appear.
        @(negedge clk);
        start_valid = 1'b1; op = 3'd0; a = 32'h1234_5678; b = 32'h1111_1111;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("mid_run_busy", {done_valid, start_ready}, 2'b00);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reset", {start_ready, done_valid, carryout, overflow, zero, result},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        @(negedge clk);
        reset = 1'b0;
        prev_res = '0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_stale_done", done_valid, 1'b0);
        run_op(3'd0, 32'd3, 32'd4, 0);

        // Reset on the same edge as a handshake drops the request.
        @(negedge clk);
        start_valid = 1'b1; reset = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        prev_res = '0;
        chk("rst_prio_ready", start_ready, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        chk("rst_prio_done", {done_valid, start_ready}, 2'b01);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = (i % 8 == 0) ? ra : 32'($urandom);
            if (i % 10 == 1) ra = 32'h8000_0000;
            run_op(ro, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
